ahb_subordinate: RTL and testbench
==================================

# ahb_subordinate

AHB 2.0 subordinate (slave) that terminates transfers issued by `ahb_manager_top` or any AHB manager and converts them into a simple request/acknowledge memory-port handshake. It sits between the AHB interconnect and a local memory or register bank. It decodes a fixed address window, generates byte enables, and inserts wait states until the memory acknowledges. It returns two-cycle ERROR responses for illegal accesses and never issues RETRY or SPLIT.

## Interface
- `DATA_WDT`, 32, AHB/memory data width; legal values are 32 and 64.
- `BASE_ADDR`, 32'h0000_0000, first byte address of the decoded window; must be aligned to `ADDR_SPAN`.
- `ADDR_SPAN`, 32'h0000_1000, window size in bytes; must be a power of two.
- `i_hclk` in 1: single clock.
- `i_hreset_n` in 1: reset, asynchronous, active-low.
- `i_hsel` in 1: subordinate select from the decoder.
- `i_haddr` in 32: address-phase address.
- `i_htrans` in t_htrans: IDLE, BUSY, NONSEQ or SEQ.
- `i_hwrite` in 1: 1 selects write.
- `i_hsize` in t_hsize: transfer size.
- `i_hburst` in t_hburst: accepted and ignored; each beat is decoded independently.
- `i_hwdata` in DATA_WDT: write data, valid in the data phase.
- `i_hready` in 1: bus-level HREADY; an address phase is sampled only when it is 1.
- `o_hreadyout` out 1: this subordinate's HREADY.
- `o_hresp` out t_hresp: OKAY or ERROR only.
- `o_hrdata` out DATA_WDT: read data.
- `o_mem_req` out 1: memory access request, held until acknowledged.
- `o_mem_wr` out 1: 1 selects write.
- `o_mem_addr` out 32: byte offset from `BASE_ADDR`.
- `o_mem_be` out DATA_WDT/8: byte enables.
- `o_mem_wdata` out DATA_WDT: equals `i_hwdata`.
- `i_mem_rdata` in DATA_WDT: read data, valid when `i_mem_ack`=1.
- `i_mem_ack` in 1: completes the outstanding request; may be asserted in the same cycle as `o_mem_req`.

## Operation
Address phase sample:
- Sampled when `i_hsel & i_hready` is 1.
- htrans=NONSEQ or SEQ is an active transfer. IDLE, BUSY and hsel=0 are not transfers.

Active transfer checks, in priority order; any failure gives ERROR:
- haddr is outside [BASE_ADDR, BASE_ADDR+ADDR_SPAN).
- hsize selects more bytes than DATA_WDT/8 holds.
- haddr is not aligned to hsize.

State machine (reset state IDLE):
- IDLE: hreadyout=1, hresp=OKAY, mem_req=0.
  - Legal active sample goes to ACCESS.
  - Illegal active sample goes to ERR1.
  - Anything else stays in IDLE.
- ACCESS: mem_req=1, hresp=OKAY, hreadyout=`i_mem_ack`.
  - While ack=0: stay in ACCESS.
  - On ack=1: the data phase completes, and the next address phase is sampled in the same cycle. Next state is ACCESS, ERR1 or IDLE according to the rules above.
- ERR1: hreadyout=0, hresp=ERROR, mem_req=0. Unconditionally goes to ERR2.
- ERR2: hreadyout=1, hresp=ERROR. Samples the next address phase exactly as IDLE does.

Registered at each accepted address phase, held constant through the data phase:
- `o_mem_wr`.
- `o_mem_addr` = haddr - BASE_ADDR.
- `o_mem_be` = (2^(2^hsize) - 1) shifted left by haddr[log2(DATA_WDT/8)-1:0].

Data paths:
- `o_hrdata` is a combinational pass-through of `i_mem_rdata` in ACCESS; it is 0 otherwise.
- `o_mem_wdata` is a combinational pass-through of `i_hwdata`.

## Timing
- Reset values, applied asynchronously:
  - hreadyout=1, hresp=OKAY, hrdata=0.
  - mem_req=0, mem_wr=0, mem_addr=0, mem_be=0.
- Latency: zero wait states when the memory acks in the first data-phase cycle. Each cycle of ack delay adds one wait state.
- `o_mem_req` never deasserts before ack. Exactly one ack is consumed per request.
- Acks arriving while `o_mem_req`=0 are ignored.
- ERROR response takes exactly two cycles: hreadyout 0 then 1, with hresp=ERROR in both.
- A manager that cancels with IDLE during ERR1 is not sampled, because hready=0. The IDLE is seen during ERR2.
- BUSY or IDLE inside a burst gets a zero-wait OKAY and produces no memory access.
- Back-to-back NONSEQ/SEQ beats with ack held at 1 give one memory access per cycle.
- Reset asserted mid-ACCESS drops `o_mem_req` immediately. The outstanding memory access is abandoned.

## Structure
- Add to `ahb_manager_pack`:
  - the state enum `t_sub_state` (IDLE, ACCESS, ERR1, ERR2);
  - the function `f_byte_en(t_hsize, logic [2:0] lsb)`.
- Reuse the existing `t_htrans`, `t_hresp`, `t_hsize` and `t_hburst` types.
- No sub-module: a single FSM with its address-phase registers.

## Test plan
- Single read at 0x10, ack in the same cycle, rdata=0xDEADBEEF -> hrdata=0xDEADBEEF with hreadyout=1 in the first data-phase cycle, mem_addr=0x10, mem_be=4'hF.
- Byte write (hsize=BYTE) at 0x13 with hwdata=0xAA000000, ack delayed 3 cycles -> hreadyout=0 for 3 cycles, then 1; mem_be=4'h8; req held steady for 4 cycles.
- INCR4 read at 0x20 with a BUSY after beat 2, ack always 1 -> four memory accesses at offsets 0x20, 0x24, 0x28, 0x2C; the BUSY beat gets a zero-wait OKAY with no mem_req.
- Write to 0x1000 with a 4 KB span -> hresp=ERROR for 2 cycles, hreadyout 0 then 1, no mem_req. Repeat with a halfword at 0x01 -> same ERROR response.
- NONSEQ at 0x0 followed by back-to-back SEQ at 0x4 with ack=1 -> continuous hreadyout=1, two accesses in consecutive cycles.
- Reset asserted in ACCESS with ack=0 -> mem_req=0 and hreadyout=1 immediately, state IDLE; the next transfer after reset completes normally.

Source files
------------

// File: rtl/ahb_manager_pack.sv
// Shared AHB 2.0 types for the manager and subordinate blocks, plus the
// subordinate FSM state enum and byte-enable helper.
package ahb_manager_pack;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } t_htrans;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } t_hresp;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3,
    HSIZE_4W    = 3'd4,
    HSIZE_8W    = 3'd5,
    HSIZE_16W   = 3'd6,
    HSIZE_32W   = 3'd7
  } t_hsize;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } t_hburst;

  typedef enum logic [1:0] {
    SUB_IDLE   = 2'd0,
    SUB_ACCESS = 2'd1,
    SUB_ERR1   = 2'd2,
    SUB_ERR2   = 2'd3
  } t_sub_state;

  // Byte lanes for a transfer of 'size' starting at byte lane 'lsb' of a
  // 64-bit lane set; narrower buses keep the low bits.
  function automatic logic [7:0] f_byte_en(t_hsize size, logic [2:0] lsb);
    logic [7:0] base;
    case (size)
      HSIZE_BYTE: base = 8'h01;
      HSIZE_HALF: base = 8'h03;
      HSIZE_WORD: base = 8'h0F;
      default:    base = 8'hFF;
    endcase
    return base << lsb;
  endfunction

endpackage

// File: rtl/ahb_subordinate.sv
// AHB 2.0 subordinate: decodes a fixed window and turns each beat into a
// req/ack memory access, with two-cycle ERROR responses for illegal beats.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   SUB_IDLE   | no data phase pending, zero-wait OKAY, samples addr phase
//   SUB_ACCESS | memory request outstanding, waits on i_mem_ack
//   SUB_ERR1   | first ERROR cycle, hreadyout low
//   SUB_ERR2   | second ERROR cycle, hreadyout high, samples addr phase
module ahb_subordinate
  import ahb_manager_pack::*;
#(
  parameter int          DATA_WDT  = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_SPAN = 32'h0000_1000
) (
  input  logic                  i_hclk,
  input  logic                  i_hreset_n,
  input  logic                  i_hsel,
  input  logic [31:0]           i_haddr,
  input  t_htrans               i_htrans,
  input  logic                  i_hwrite,
  input  t_hsize                i_hsize,
  input  t_hburst               i_hburst,
  input  logic [DATA_WDT-1:0]   i_hwdata,
  input  logic                  i_hready,
  output logic                  o_hreadyout,
  output t_hresp                o_hresp,
  output logic [DATA_WDT-1:0]   o_hrdata,
  output logic                  o_mem_req,
  output logic                  o_mem_wr,
  output logic [31:0]           o_mem_addr,
  output logic [DATA_WDT/8-1:0] o_mem_be,
  output logic [DATA_WDT-1:0]   o_mem_wdata,
  input  logic [DATA_WDT-1:0]   i_mem_rdata,
  input  logic                  i_mem_ack
);

  localparam int BYTES = DATA_WDT / 8;
  localparam int LSB_W = $clog2(BYTES);

  t_sub_state          state_q, state_d;
  t_hresp              hresp_q, hresp_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_wr_q, mem_wr_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [BYTES-1:0]    mem_be_q, mem_be_d;

  logic                active;
  logic                sample_en;
  logic                in_window;
  logic                size_ok;
  logic                aligned;
  logic                legal;
  logic [31:0]         offset;
  logic [31:0]         align_mask;
  logic [2:0]          size_num;
  logic [2:0]          lsb;
  logic [7:0]          be_full;
  logic                unused_ok;

  always_comb begin
    size_num   = i_hsize;
    offset     = i_haddr - BASE_ADDR;
    in_window  = (i_haddr >= BASE_ADDR) && (offset < ADDR_SPAN);
    size_ok    = (size_num <= 3'(LSB_W));
    align_mask = (32'h1 << size_num) - 32'h1;
    aligned    = ((i_haddr & align_mask) == 32'h0);
    legal      = in_window && size_ok && aligned;
    active     = i_hsel && i_hready &&
                 ((i_htrans == HTRANS_NONSEQ) || (i_htrans == HTRANS_SEQ));
    lsb        = i_haddr[2:0] & 3'(BYTES - 1);
    be_full    = f_byte_en(i_hsize, lsb);
  end

  // An address phase is only seen when our own data phase is finishing.
  assign sample_en = (state_q == SUB_IDLE) || (state_q == SUB_ERR2) ||
                     ((state_q == SUB_ACCESS) && i_mem_ack);

  always_comb begin
    state_d    = state_q;
    mem_wr_d   = mem_wr_q;
    mem_addr_d = mem_addr_q;
    mem_be_d   = mem_be_q;
    case (state_q)
      SUB_ERR1: state_d = SUB_ERR2;
      default: begin
        if (sample_en) begin
          if (!active) begin
            state_d = SUB_IDLE;
          end else if (!legal) begin
            state_d = SUB_ERR1;
          end else begin
            state_d    = SUB_ACCESS;
            mem_wr_d   = i_hwrite;
            mem_addr_d = offset;
            mem_be_d   = be_full[BYTES-1:0];
          end
        end
      end
    endcase
    mem_req_d = (state_d == SUB_ACCESS);
    hresp_d   = ((state_d == SUB_ERR1) || (state_d == SUB_ERR2)) ? HRESP_ERROR
                                                                 : HRESP_OKAY;
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      state_q    <= SUB_IDLE;
      hresp_q    <= HRESP_OKAY;
      mem_req_q  <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= 32'h0;
      mem_be_q   <= '0;
    end else begin
      state_q    <= state_d;
      hresp_q    <= hresp_d;
      mem_req_q  <= mem_req_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_be_q   <= mem_be_d;
    end
  end

  assign o_hreadyout = (state_q == SUB_ACCESS) ? i_mem_ack : (state_q != SUB_ERR1);
  assign o_hresp     = hresp_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_wr    = mem_wr_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_be    = mem_be_q;
  assign o_mem_wdata = i_hwdata;
  assign o_hrdata    = (state_q == SUB_ACCESS) ? i_mem_rdata : '0;

  assign unused_ok = ^{i_hburst, be_full};

endmodule

// File: tb/tb_ahb_subordinate.sv
// Directed bench for ahb_subordinate: drives on the falling edge, checks
// outputs 2 ns later, and compares against hand-computed expectations.
module tb_ahb_subordinate;
  import ahb_manager_pack::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel;
  logic [31:0] haddr;
  t_htrans     htrans;
  logic        hwrite;
  t_hsize      hsize;
  t_hburst     hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  t_hresp      hresp;
  logic [31:0] hrdata;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_vec  = 0;
  int n_miss = 0;
  int n_acc  = 0;

  always #5 clk = ~clk;

  assign hready = hreadyout;

  ahb_subordinate dut (
    .i_hclk      (clk),
    .i_hreset_n  (rst_n),
    .i_hsel      (hsel),
    .i_haddr     (haddr),
    .i_htrans    (htrans),
    .i_hwrite    (hwrite),
    .i_hsize     (hsize),
    .i_hburst    (hburst),
    .i_hwdata    (hwdata),
    .i_hready    (hready),
    .o_hreadyout (hreadyout),
    .o_hresp     (hresp),
    .o_hrdata    (hrdata),
    .o_mem_req   (mem_req),
    .o_mem_wr    (mem_wr),
    .o_mem_addr  (mem_addr),
    .o_mem_be    (mem_be),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .i_mem_ack   (mem_ack)
  );

  always @(posedge clk) begin
    if (mem_req && mem_ack) n_acc <= n_acc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input t_htrans tr, input logic [31:0] a, input logic wr, input t_hsize sz);
    hsel   = 1'b1;
    htrans = tr;
    haddr  = a;
    hwrite = wr;
    hsize  = sz;
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic check_error(input string tag);
    // Data phase 1: ERR1
    step; drive(HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD); settle;
    chk({tag, "_e1_rdy"}, 32'(hreadyout), 32'd0);
    chk({tag, "_e1_resp"}, 32'(hresp), 32'(HRESP_ERROR));
    chk({tag, "_e1_req"}, 32'(mem_req), 32'd0);
    step; settle;
    chk({tag, "_e2_rdy"}, 32'(hreadyout), 32'd1);
    chk({tag, "_e2_resp"}, 32'(hresp), 32'(HRESP_ERROR));
    chk({tag, "_e2_req"}, 32'(mem_req), 32'd0);
    step; settle;
    chk({tag, "_after_resp"}, 32'(hresp), 32'(HRESP_OKAY));
  endtask

  initial begin
    int acc0;
    rst_n     = 1'b0;
    hsel      = 1'b0;
    haddr     = 32'h0;
    htrans    = HTRANS_IDLE;
    hwrite    = 1'b0;
    hsize     = HSIZE_WORD;
    hburst    = HBURST_SINGLE;
    hwdata    = 32'h0;
    mem_rdata = 32'h0;
    mem_ack   = 1'b0;

    #12;
    chk("rst_rdy",   32'(hreadyout), 32'd1);
    chk("rst_resp",  32'(hresp), 32'(HRESP_OKAY));
    chk("rst_rdata", hrdata, 32'h0);
    chk("rst_req",   32'(mem_req), 32'd0);
    chk("rst_wr",    32'(mem_wr), 32'd0);
    chk("rst_addr",  mem_addr, 32'h0);
    chk("rst_be",    32'(mem_be), 32'h0);
    step; rst_n = 1'b1;

    // Single read at 0x10, ack in the first data-phase cycle
    step; drive(HTRANS_NONSEQ, 32'h10, 1'b0, HSIZE_WORD);
    step; drive(HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; settle;
    chk("rd_rdata", hrdata, 32'hDEADBEEF);
    chk("rd_rdy",   32'(hreadyout), 32'd1);
    chk("rd_req",   32'(mem_req), 32'd1);
    chk("rd_wr",    32'(mem_wr), 32'd0);
    chk("rd_addr",  mem_addr, 32'h10);
    chk("rd_be",    32'(mem_be), 32'hF);
    step; mem_ack = 1'b0; settle;
    chk("rd_done_req", 32'(mem_req), 32'd0);
    chk("rd_done_rdata", hrdata, 32'h0);

    // Byte write at 0x13, ack three cycles late
    step; drive(HTRANS_NONSEQ, 32'h13, 1'b1, HSIZE_BYTE);
    step; drive(HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD); hwdata = 32'hAA000000;
    for (int i = 0; i < 3; i++) begin
      settle;
      chk($sformatf("bw_wait%0d_rdy", i), 32'(hreadyout), 32'd0);
      chk($sformatf("bw_wait%0d_req", i), 32'(mem_req), 32'd1);
      chk($sformatf("bw_wait%0d_be", i),  32'(mem_be), 32'h8);
      step;
    end
    mem_ack = 1'b1; settle;
    chk("bw_rdy",   32'(hreadyout), 32'd1);
    chk("bw_req",   32'(mem_req), 32'd1);
    chk("bw_wr",    32'(mem_wr), 32'd1);
    chk("bw_addr",  mem_addr, 32'h13);
    chk("bw_wdata", mem_wdata, 32'hAA000000);
    step; mem_ack = 1'b0; settle;
    chk("bw_done_req", 32'(mem_req), 32'd0);

    // INCR4 read at 0x20 with a BUSY after beat 2, ack held high
    acc0 = n_acc; mem_ack = 1'b1; mem_rdata = 32'h1234;
    hburst = HBURST_INCR4;
    step; drive(HTRANS_NONSEQ, 32'h20, 1'b0, HSIZE_WORD);
    step; drive(HTRANS_SEQ, 32'h24, 1'b0, HSIZE_WORD); settle;
    chk("b4_0_addr", mem_addr, 32'h20);
    chk("b4_0_rdy",  32'(hreadyout), 32'd1);
    step; drive(HTRANS_BUSY, 32'h28, 1'b0, HSIZE_WORD); settle;
    chk("b4_1_addr", mem_addr, 32'h24);
    step; drive(HTRANS_SEQ, 32'h28, 1'b0, HSIZE_WORD); settle;
    chk("b4_busy_req",  32'(mem_req), 32'd0);
    chk("b4_busy_rdy",  32'(hreadyout), 32'd1);
    chk("b4_busy_resp", 32'(hresp), 32'(HRESP_OKAY));
    step; drive(HTRANS_SEQ, 32'h2C, 1'b0, HSIZE_WORD); settle;
    chk("b4_2_addr", mem_addr, 32'h28);
    step; drive(HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD); settle;
    chk("b4_3_addr", mem_addr, 32'h2C);
    chk("b4_3_req",  32'(mem_req), 32'd1);
    step; settle;
    chk("b4_accesses", 32'(n_acc - acc0), 32'd4);
    chk("b4_idle_req", 32'(mem_req), 32'd0);
    hburst = HBURST_SINGLE; mem_ack = 1'b0;

    // Out-of-window, misaligned and oversize beats
    step; drive(HTRANS_NONSEQ, 32'h1000, 1'b1, HSIZE_WORD);
    check_error("oow");
    step; drive(HTRANS_NONSEQ, 32'h01, 1'b0, HSIZE_HALF);
    check_error("misal");
    step; drive(HTRANS_NONSEQ, 32'h08, 1'b0, HSIZE_DWORD);
    check_error("oversz");

    // Last word of the window is legal
    step; drive(HTRANS_NONSEQ, 32'hFFC, 1'b0, HSIZE_WORD);
    step; drive(HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD); mem_ack = 1'b1; settle;
    chk("top_req",  32'(mem_req), 32'd1);
    chk("top_resp", 32'(hresp), 32'(HRESP_OKAY));
    chk("top_addr", mem_addr, 32'hFFC);
    step; mem_ack = 1'b0;

    // Halfword at 0x12 uses upper lanes
    step; drive(HTRANS_NONSEQ, 32'h12, 1'b1, HSIZE_HALF);
    step; drive(HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD); mem_ack = 1'b1; settle;
    chk("hw_be", 32'(mem_be), 32'hC);
    step; mem_ack = 1'b0;

    // NONSEQ 0x0 then SEQ 0x4 back-to-back
    acc0 = n_acc; mem_ack = 1'b1;
    step; drive(HTRANS_NONSEQ, 32'h0, 1'b0, HSIZE_WORD);
    step; drive(HTRANS_SEQ, 32'h4, 1'b0, HSIZE_WORD); settle;
    chk("bb_0_rdy",  32'(hreadyout), 32'd1);
    chk("bb_0_addr", mem_addr, 32'h0);
    step; drive(HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD); settle;
    chk("bb_1_rdy",  32'(hreadyout), 32'd1);
    chk("bb_1_addr", mem_addr, 32'h4);
    step; settle;
    chk("bb_accesses", 32'(n_acc - acc0), 32'd2);
    mem_ack = 1'b0;

    // Reset while an access is outstanding
    step; drive(HTRANS_NONSEQ, 32'h40, 1'b0, HSIZE_WORD);
    step; drive(HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD); settle;
    chk("rm_pre_req", 32'(mem_req), 32'd1);
    chk("rm_pre_rdy", 32'(hreadyout), 32'd0);
    rst_n = 1'b0; #1;
    chk("rm_req",  32'(mem_req), 32'd0);
    chk("rm_rdy",  32'(hreadyout), 32'd1);
    chk("rm_addr", mem_addr, 32'h0);
    step; rst_n = 1'b1;
    step; drive(HTRANS_NONSEQ, 32'h8, 1'b0, HSIZE_WORD);
    step; drive(HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD);
    mem_ack = 1'b1; mem_rdata = 32'h12345678; settle;
    chk("rm_next_rdata", hrdata, 32'h12345678);
    chk("rm_next_addr",  mem_addr, 32'h8);
    chk("rm_next_rdy",   32'(hreadyout), 32'd1);
    step; mem_ack = 1'b0; hsel = 1'b0;
    step;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
